// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_pkg
//  Description : Shared pipeline register-file widths, types and constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_ZERO   = 0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_read_port
//  Description : One combinational register-file read port: array select,
//                zero-register mask and optional write-to-read bypass.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_read_port
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_W,
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS_EN  = 0
) (
    input  logic [(2**ADDR_WIDTH)-1:0][DATA_WIDTH-1:0] i_mem,
    input  logic [ADDR_WIDTH-1:0]                      i_addr,
    input  logic                                       i_wr_en,
    input  logic [ADDR_WIDTH-1:0]                      i_wr_addr,
    input  logic [DATA_WIDTH-1:0]                      i_wr_data,
    output logic [DATA_WIDTH-1:0]                      o_data
);

    localparam logic [ADDR_WIDTH-1:0] c_ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

    logic [DATA_WIDTH-1:0] w_array_data;
    logic [DATA_WIDTH-1:0] w_path_data;
    logic                  w_is_zero;

    assign w_array_data = i_mem[i_addr];
    assign w_is_zero    = (ZERO_REG != 0) && (i_addr == c_ZERO_ADDR);

    generate
        if (BYPASS_EN != 0) begin : g_bypass
            assign w_path_data = (i_wr_en && (i_wr_addr == i_addr)) ? i_wr_data : w_array_data;
        end else begin : g_no_bypass
            logic w_unused;
            assign w_unused    = &{1'b0, i_wr_en, i_wr_addr, i_wr_data};
            assign w_path_data = w_array_data;
        end
    endgenerate

    // The zero mask sits after the bypass so a pending write to r0 never leaks.
    assign o_data = w_is_zero ? '0 : w_path_data;

endmodule
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
//  Module      : register_file
//  Description : Synchronous-write, asynchronous-read register file with two
//                operand ports and one debug port. Define REGFILE_BYPASS_EN to
//                forward a same-cycle write onto the operand ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_file
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_W,
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] read_addr_a,
    input  logic [ADDR_WIDTH-1:0] read_addr_b,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] data_b,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    localparam int                    c_DEPTH     = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);
`ifdef REGFILE_BYPASS_EN
    localparam int                    c_BYPASS    = 1;
`else
    localparam int                    c_BYPASS    = 0;
`endif

    logic [c_DEPTH-1:0][DATA_WIDTH-1:0] r_mem;
    logic                               w_wr_blocked;
    logic                               w_wr_en;

    generate
        if (ZERO_REG != 0) begin : g_zero_reg
            assign w_wr_blocked = (write_address == c_ZERO_ADDR);
        end else begin : g_plain_reg
            assign w_wr_blocked = 1'b0;
        end
    endgenerate

    // Reset takes priority, so a colliding write is simply lost.
    assign w_wr_en = reg_write & ~reset & ~w_wr_blocked;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem <= '0;
        end else if (w_wr_en) begin
            r_mem[write_address] <= write_data;
        end
    end

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG),
        .BYPASS_EN  (c_BYPASS)
    ) u_port_a (
        .i_mem      (r_mem),
        .i_addr     (read_addr_a),
        .i_wr_en    (w_wr_en),
        .i_wr_addr  (write_address),
        .i_wr_data  (write_data),
        .o_data     (data_a)
    );

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG),
        .BYPASS_EN  (c_BYPASS)
    ) u_port_b (
        .i_mem      (r_mem),
        .i_addr     (read_addr_b),
        .i_wr_en    (w_wr_en),
        .i_wr_addr  (write_address),
        .i_wr_data  (write_data),
        .o_data     (data_b)
    );

    // Debug always observes the committed array, never the in-flight write.
    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG),
        .BYPASS_EN  (0)
    ) u_port_dbg (
        .i_mem      (r_mem),
        .i_addr     (dbg_addr),
        .i_wr_en    (w_wr_en),
        .i_wr_addr  (write_address),
        .i_wr_data  (write_data),
        .o_data     (dbg_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_file
//  Description : Self-checking bench for register_file (ZERO_REG=1 and 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file;

`ifdef REGFILE_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  read_addr_a, read_addr_b, write_address, dbg_addr;
    logic [31:0] write_data;
    logic        reg_write;
    logic [31:0] data_a_z, data_b_z, dbg_data_z;
    logic [31:0] data_a_n, data_b_n, dbg_data_n;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] m_z  [32];
    logic [31:0] m_nz [32];

    always #5 clk = ~clk;

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1)) dut_z (
        .clk(clk), .reset(reset), .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
        .write_address(write_address), .write_data(write_data), .reg_write(reg_write),
        .dbg_addr(dbg_addr), .data_a(data_a_z), .data_b(data_b_z), .dbg_data(dbg_data_z)
    );

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0)) dut_nz (
        .clk(clk), .reset(reset), .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
        .write_address(write_address), .write_data(write_data), .reg_write(reg_write),
        .dbg_addr(dbg_addr), .data_a(data_a_n), .data_b(data_b_n), .dbg_data(dbg_data_n)
    );

    // Reference read: zero reg first, then same-cycle forwarding, then stored value.
    function automatic logic [31:0] exp_rd(input bit nz, input logic [4:0] a, input bit byp_ok);
        if (!nz && a == 5'd0) return 32'h0;
        if (byp_ok && c_BYP && reg_write && !reset && a == write_address) return write_data;
        return nz ? m_nz[a] : m_z[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_z[i]  = 32'h0;
            m_nz[i] = 32'h0;
        end
    endtask

    task automatic step(input logic rs, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] da);
        reset = rs; reg_write = we; write_address = wa; write_data = wd;
        read_addr_a = ra; read_addr_b = rb; dbg_addr = da;
        @(negedge clk);
        chk("z_data_a",   data_a_z,   exp_rd(1'b0, ra, 1'b1));
        chk("z_data_b",   data_b_z,   exp_rd(1'b0, rb, 1'b1));
        chk("z_dbg_data", dbg_data_z, exp_rd(1'b0, da, 1'b0));
        chk("n_data_a",   data_a_n,   exp_rd(1'b1, ra, 1'b1));
        chk("n_data_b",   data_b_n,   exp_rd(1'b1, rb, 1'b1));
        chk("n_dbg_data", dbg_data_n, exp_rd(1'b1, da, 1'b0));
        @(posedge clk);
        if (rs) begin
            model_clear();
        end else if (we) begin
            if (wa != 5'd0) m_z[wa] = wd;
            m_nz[wa] = wd;
        end
        #1;
    endtask

    initial begin
        reset = 1'b1; reg_write = 1'b0; write_address = '0; write_data = '0;
        read_addr_a = '0; read_addr_b = '0; dbg_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();

        // Reset then read
        step(0, 0, 5'd0, 32'h0, 5'd0, 5'd7, 5'd31);
        step(0, 0, 5'd0, 32'h0, 5'd31, 5'd0, 5'd7);

        // Write/readback
        step(0, 1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2, 5'd5);
        step(0, 0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);

        // Zero register
        step(0, 1, 5'd0, 32'h12345678, 5'd0, 5'd0, 5'd0);
        step(0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);

        // Same-cycle hazard on r9
        step(0, 1, 5'd9, 32'h11, 5'd9, 5'd4, 5'd9);
        step(0, 1, 5'd9, 32'h22, 5'd9, 5'd9, 5'd9);
        step(0, 0, 5'd0, 32'h0, 5'd9, 5'd9, 5'd9);

        // Write to r0 with r0 also being read (bypass must not beat the zero mask)
        step(0, 1, 5'd0, 32'hCAFEF00D, 5'd0, 5'd0, 5'd0);

        // Reset collision, then write followed by reset
        step(1, 1, 5'd3, 32'hAA, 5'd3, 5'd5, 5'd3);
        step(0, 0, 5'd0, 32'h0, 5'd3, 5'd5, 5'd9);
        step(0, 1, 5'd3, 32'h55, 5'd3, 5'd3, 5'd3);
        step(1, 0, 5'd0, 32'h0, 5'd3, 5'd3, 5'd3);
        step(0, 0, 5'd0, 32'h0, 5'd3, 5'd0, 5'd3);

        // Back-to-back writes r1..r31 = index*3
        for (int i = 1; i < 32; i++)
            step(0, 1, 5'(i), 32'(i * 3), 5'(i), 5'(i - 1), 5'(i));

        // Random read sweep
        for (int i = 0; i < 40; i++)
            step(0, 0, 5'($urandom), $urandom, 5'($urandom), 5'($urandom), 5'($urandom));

        // Random mixed traffic with occasional reset and forced address collisions
        for (int i = 0; i < 200; i++) begin
            logic [4:0] wa;
            logic [4:0] ra;
            wa = 5'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            step(($urandom_range(0, 15) == 0), $urandom_range(0, 1) != 0, wa, $urandom,
                 ra, 5'($urandom), ($urandom_range(0, 3) == 0) ? wa : 5'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
